// File: rtl/arc4_encrypt.sv
// ARC4 encryptor (24-bit key): reads a length-prefixed plaintext and writes a length-prefixed ciphertext.
// Runs in 772 + 4*L cycles from the start cycle to rdy. en is accepted only while rdy is high. ct writes are single-cycle pulses that are never stalled.
module arc4_encrypt #(
    parameter int KEY_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic [7:0]       ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_KSA_J, ST_KSA_SWAP, ST_LEN_RD, ST_LEN_WR,
        ST_PRGA_I, ST_PRGA_J, ST_PRGA_SWAP, ST_PRGA_OUT, ST_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [7:0]       i_q, i_d, j_q, j_d, len_q, len_d, pt_dat_q, pt_dat_d;
    logic [7:0]       pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic [8:0]       k_q, k_d;
    logic [1:0]       kidx_q, kidx_d;
    logic             ct_wren_q, ct_wren_d;

    logic [7:0] sbox_q [256];
    logic       s_we_a, s_we_b;
    logic [7:0] s_addr_a, s_dat_a, s_addr_b, s_dat_b;
    logic [7:0] s_i, s_j, pad_idx, pad, key_byte;

    assign s_i     = sbox_q[i_q];
    assign s_j     = sbox_q[j_q];
    assign pad_idx = s_i + s_j;
    assign pad     = sbox_q[pad_idx];

    // kidx_q tracks i mod 3 alongside i, so no divider is needed
    always_comb begin
        case (kidx_q)
            2'd0:    key_byte = key_q[KEY_W-1 -: 8];
            2'd1:    key_byte = key_q[KEY_W-9 -: 8];
            default: key_byte = key_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (en) state_d = ST_INIT;
            ST_INIT:      if (i_q == 8'd255) state_d = ST_KSA_J;
            ST_KSA_J:     state_d = ST_KSA_SWAP;
            ST_KSA_SWAP:  state_d = (i_q == 8'd255) ? ST_LEN_RD : ST_KSA_J;
            ST_LEN_RD:    state_d = ST_LEN_WR;
            ST_LEN_WR:    state_d = (pt_rddata == 8'd0) ? ST_FIN : ST_PRGA_I;
            ST_PRGA_I:    state_d = ST_PRGA_J;
            ST_PRGA_J:    state_d = ST_PRGA_SWAP;
            ST_PRGA_SWAP: state_d = ST_PRGA_OUT;
            ST_PRGA_OUT:  state_d = (k_q == {1'b0, len_q}) ? ST_FIN : ST_PRGA_I;
            ST_FIN:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdy         = (state_q == ST_IDLE);
        key_d       = key_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        kidx_d      = kidx_q;
        len_d       = len_q;
        pt_dat_d    = pt_dat_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
        s_we_a      = 1'b0;
        s_we_b      = 1'b0;
        s_addr_a    = i_q;
        s_dat_a     = s_j;
        s_addr_b    = j_q;
        s_dat_b     = s_i;
        case (state_q)
            ST_IDLE: begin
                pt_addr_d = 8'd0;
                if (en) begin
                    key_d = key;
                    i_d   = 8'd0;
                end
            end
            ST_INIT: begin
                s_we_a  = 1'b1;
                s_dat_a = i_q;
                i_d     = i_q + 8'd1;
                j_d     = 8'd0;
                kidx_d  = 2'd0;
            end
            ST_KSA_J: j_d = j_q + s_i + key_byte;
            ST_KSA_SWAP: begin
                s_we_a = 1'b1;
                s_we_b = 1'b1;
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
            end
            ST_LEN_WR: begin
                len_d       = pt_rddata;
                ct_wren_d   = 1'b1;
                ct_addr_d   = 8'd0;
                ct_wrdata_d = pt_rddata;
                i_d         = 8'd0;
                j_d         = 8'd0;
                k_d         = 9'd1;
            end
            ST_PRGA_I: begin
                i_d       = i_q + 8'd1;
                pt_addr_d = k_q[7:0];
            end
            ST_PRGA_J: j_d = j_q + s_i;
            ST_PRGA_SWAP: begin
                // pt_addr has been stable for one cycle, so the read data is valid here
                s_we_a   = 1'b1;
                s_we_b   = 1'b1;
                pt_dat_d = pt_rddata;
            end
            ST_PRGA_OUT: begin
                ct_wren_d   = 1'b1;
                ct_addr_d   = k_q[7:0];
                ct_wrdata_d = pt_dat_q ^ pad;
                k_d         = k_q + 9'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 9'd0;
            kidx_q      <= 2'd0;
            len_q       <= 8'd0;
            pt_dat_q    <= 8'd0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
        end else begin
            key_q       <= key_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            kidx_q      <= kidx_d;
            len_q       <= len_d;
            pt_dat_q    <= pt_dat_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
    end

    // A swap writes both entries in one cycle; when i == j both ports carry the same value
    always_ff @(posedge clk) begin
        if (s_we_a) sbox_q[s_addr_a] <= s_dat_a;
        if (s_we_b) sbox_q[s_addr_b] <= s_dat_b;
    end

    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: fixed ARC4 vectors plus random messages checked against a software ARC4 model.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst, en, rdy, ct_wren;
    logic [23:0] key;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;

    arc4_encrypt #(.KEY_W(24)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
    );

    always #5 clk = ~clk;

    logic [7:0]  pt_mem [256];
    logic [15:0] wr_q [$];
    int          max_pt;
    int          exp_ct [256];
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  kv_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0]  kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    always @(negedge clk) begin
        if (ct_wren === 1'b1) wr_q.push_back({ct_addr, ct_wrdata});
        if (rdy === 1'b0 && int'(pt_addr) > max_pt) max_pt = int'(pt_addr);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic arc4_model(input logic [23:0] k);
        int s [256];
        int i, j, t, len;
        len = int'(pt_mem[0]);
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'((k >> (8 * (2 - n % 3))) & 24'hFF)) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        exp_ct[0] = len;
        i = 0; j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_ct[n] = int'(pt_mem[n]) ^ s[(s[i] + s[j]) % 256];
        end
    endtask

    task automatic check_log(input string tag, input int off, input int len);
        int nbad = 0;
        for (int n = 0; n <= len; n++) begin
            if (off + n >= wr_q.size()) nbad++;
            else if (int'(wr_q[off+n][15:8]) != n || int'(wr_q[off+n][7:0]) != exp_ct[n]) nbad++;
        end
        check({tag, "_bad_bytes"}, nbad, 0);
    endtask

    task automatic clear_log();
        wr_q.delete();
        max_pt = 0;
    endtask

    // Called at the negedge after the start edge; mode 0 en low, 1 en held high, 2 en pulsed
    task automatic wait_rdy(input string tag, input int len, input int mode);
        int cyc = 1;
        int bound = 256 + 1024 + 6 * (len + 1) + 8;
        while (rdy !== 1'b1 && cyc < bound) begin
            if (mode == 1) en = 1'b1;
            else if (mode == 2) en = (cyc % 37 == 0);
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
        check({tag, "_rdy_in_bound"}, int'(rdy === 1'b1), 1);
    endtask

    task automatic run(input string tag, input logic [23:0] k, input int mode);
        int len = int'(pt_mem[0]);
        @(negedge clk);
        check({tag, "_rdy_before"}, int'(rdy === 1'b1), 1);
        clear_log();
        en  = 1'b1;
        key = k;
        @(negedge clk);
        if (mode == 0) en = 1'b0;
        check({tag, "_rdy_fall"}, int'(rdy), 0);
        wait_rdy(tag, len, mode);
        arc4_model(k);
        check({tag, "_nwrites"}, wr_q.size(), len + 1);
        check_log(tag, 0, len);
        check({tag, "_pt_addr_max_ok"}, int'(max_pt <= len), 1);
    endtask

    task automatic check_kv(input string tag);
        for (int n = 0; n < 10; n++)
            check($sformatf("%s_ct%0d", tag, n), (wr_q.size() > n) ? int'(wr_q[n][7:0]) : -1, int'(kv_ct[n]));
    endtask

    task automatic load_kv();
        for (int n = 0; n < 10; n++) pt_mem[n] = kv_pt[n];
    endtask

    task automatic load_rand(input int len);
        pt_mem[0] = len[7:0];
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int n0 = wr_q.size();
        int rdy_low = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (rdy !== 1'b1) rdy_low++;
        end
        check({tag, "_no_new_writes"}, wr_q.size(), n0);
        check({tag, "_rdy_stays_high"}, rdy_low, 0);
    endtask

    task automatic reset_pulse(input string tag);
        int n0;
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, int'(rdy === 1'b1), 1);
        check({tag, "_ct_wren"}, int'(ct_wren === 1'b1), 0);
        n0 = wr_q.size();
        rst = 1'b0;
        check_quiet(tag, 40);
        check({tag, "_partial_writes"}, int'(n0 < 10), 1);
    endtask

    initial begin
        int cyc;
        logic [23:0] rk;
        rst = 1'b1; en = 1'b0; key = 24'h0;
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        clear_log();
        repeat (3) @(negedge clk);
        check("rst_rdy", int'(rdy === 1'b1), 1);
        check("rst_ct_wren", int'(ct_wren === 1'b1), 0);
        check("rst_ct_addr", int'(ct_addr), 0);
        check("rst_ct_wrdata", int'(ct_wrdata), 0);
        check("rst_pt_addr", int'(pt_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", int'(rdy === 1'b1), 1);
        check("post_rst_ct_wren", int'(ct_wren === 1'b1), 0);
        check("post_rst_pt_addr", int'(pt_addr), 0);

        load_kv();
        run("kv", 24'h4B6579, 0);
        check_kv("kv");

        for (int n = 0; n < 10; n++) pt_mem[n] = (wr_q.size() > n) ? wr_q[n][7:0] : 8'h00;
        run("roundtrip", 24'h4B6579, 0);
        for (int n = 0; n < 10; n++)
            check($sformatf("roundtrip_pt%0d", n), (wr_q.size() > n) ? int'(wr_q[n][7:0]) : -1, int'(kv_pt[n]));

        load_rand(0);
        run("len0", 24'($urandom), 0);

        load_rand(255);
        run("len255", 24'($urandom), 0);

        load_rand(20);
        run("en_held", 24'($urandom), 1);
        check_quiet("en_held_idle", 30);
        load_rand(13);
        run("en_pulsed", 24'($urandom), 2);
        check_quiet("en_pulsed_idle", 30);

        // Back-to-back: the second start is sampled in the very cycle rdy rises
        load_rand(7);
        @(negedge clk);
        clear_log();
        en = 1'b1; key = 24'h000000;
        @(negedge clk);
        en = 1'b0;
        wait_rdy("b2b_a", 7, 0);
        en = 1'b1; key = 24'hFFFFFF;
        @(negedge clk);
        en = 1'b0;
        check("b2b_restart_rdy_low", int'(rdy), 0);
        wait_rdy("b2b_b", 7, 0);
        check("b2b_nwrites", wr_q.size(), 16);
        arc4_model(24'h000000);
        check_log("b2b_a", 0, 7);
        arc4_model(24'hFFFFFF);
        check_log("b2b_b", 8, 7);

        // Reset during KSA: INIT is exactly 256 cycles, so 400 cycles in is past it
        load_kv();
        @(negedge clk);
        clear_log();
        en = 1'b1; key = 24'h4B6579;
        @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        reset_pulse("rst_ksa");

        // Reset during PRGA: wait for ct[0] and ct[1] to appear first
        @(negedge clk);
        clear_log();
        en = 1'b1; key = 24'h4B6579;
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        while (wr_q.size() < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_prga_reached", int'(wr_q.size() >= 2), 1);
        reset_pulse("rst_prga");

        rk = 24'h4B6579;
        run("kv_after_rst", rk, 0);
        check_kv("kv_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
